// File: rtl/img_out_pkg.sv
// img_out_pkg: shared definitions for the img_out VGA output stage.
//   - 640x480@60 VGA timing constants (counts in 25 MHz pixel ticks / lines)
//   - counter width used by the scan counters
//   - grey_to_rgb332: maps an 8-bit grey level onto the 3/3/2 VGA DAC pins
package img_out_pkg;

    localparam int H_VIS    = 640;
    localparam int H_SYNC_S = 656;
    localparam int H_SYNC_E = 751;
    localparam int H_TOT    = 800;
    localparam int V_VIS    = 480;
    localparam int V_SYNC_S = 490;
    localparam int V_SYNC_E = 491;
    localparam int V_TOT    = 521;

    localparam int CNT_W    = 10;

    // Grey level to RGB332: red and green take the top three bits, blue the top two.
    function automatic logic [7:0] grey_to_rgb332(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6]};
    endfunction

endpackage

// File: rtl/img_out_if.sv
// img_out_if: raster pixel stream from the Sobel operator into img_out.
//   in_pix   : 8-bit processed grey pixel
//   in_valid : in_pix valid this cycle
//   in_sof   : qualifies in_valid, pixel is first of frame
//   in_ready : sink accepts data
// master = pixel producer, slave = img_out.
interface img_out_if;
    logic [7:0] in_pix;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;

    modport master (output in_pix, output in_valid, output in_sof, input in_ready);
    modport slave  (input in_pix, input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/img_out_vga_timing.sv
// img_out_vga_timing: 640x480 VGA scan generator.
//   clk     in   50 MHz system clock
//   rst     in   asynchronous active-low reset
//   ce      out  pixel enable, toggles every clk (25 MHz pixel rate)
//   hcntr   out  horizontal position 0..799, advances on ce
//   vcntr   out  line number 0..520, advances at end of each line
//   visible out  counters inside the 640x480 active area
//   hs, vs  out  active-low sync decoded from the counters
module img_out_vga_timing
    import img_out_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             ce,
    output logic [CNT_W-1:0] hcntr,
    output logic [CNT_W-1:0] vcntr,
    output logic             visible,
    output logic             hs,
    output logic             vs
);

    logic             ce_r;
    logic [CNT_W-1:0] hcntr_r;
    logic [CNT_W-1:0] vcntr_r;

    // Pixel enable divider and raster counters; counters move only on ce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_r    <= 1'b0;
            hcntr_r <= '0;
            vcntr_r <= '0;
        end else begin
            ce_r <= !ce_r;
            if (ce_r) begin
                if (hcntr_r == CNT_W'(H_TOT - 1)) begin
                    hcntr_r <= '0;
                    if (vcntr_r == CNT_W'(V_TOT - 1)) begin
                        vcntr_r <= '0;
                    end else begin
                        vcntr_r <= vcntr_r + 10'd1;
                    end
                end else begin
                    hcntr_r <= hcntr_r + 10'd1;
                end
            end
        end
    end

    assign ce      = ce_r;
    assign hcntr   = hcntr_r;
    assign vcntr   = vcntr_r;
    assign visible = (hcntr_r < CNT_W'(H_VIS)) && (vcntr_r < CNT_W'(V_VIS));
    assign hs      = !((hcntr_r >= CNT_W'(H_SYNC_S)) && (hcntr_r <= CNT_W'(H_SYNC_E)));
    assign vs      = !((vcntr_r >= CNT_W'(V_SYNC_S)) && (vcntr_r <= CNT_W'(V_SYNC_E)));

endmodule

// File: rtl/img_out.sv
// img_out: output stage of the Sobel datapath. Raster pixels are written into a
// WIDTH x HEIGHT block-RAM frame buffer and scanned out as 640x480 VGA with
// SCALE-times pixel replication on both axes (image in the top-left corner).
//   clk        in   50 MHz system clock
//   rst        in   asynchronous active-low reset
//   in_if      slave pixel stream (in_pix, in_valid, in_sof, in_ready)
//   frame_done out  one-cycle pulse after the last pixel of a frame is written
//   vga_r/g/b  out  3/3/2 colour, zero outside the image or in blanking
//   vga_hs/vs  out  active-low syncs, aligned with colour (2 ce ticks after counters)
// Optional build macro IMG_OUT_THRESH_EN: display pixels binarised against THRESH.
module img_out
    import img_out_pkg::*;
#(
    parameter int         WIDTH  = 128,
    parameter int         HEIGHT = 96,
    parameter int         SCALE  = 4,
    parameter logic [7:0] THRESH = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    img_out_if.slave   in_if,
    output logic       frame_done,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    localparam int DEPTH      = WIDTH * HEIGHT;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int SCALE_LOG2 = $clog2(SCALE);
    localparam int IMG_W      = WIDTH * SCALE;
    localparam int IMG_H      = HEIGHT * SCALE;
`ifdef IMG_OUT_THRESH_EN
    localparam bit THRESH_EN  = 1'b1;
`else
    localparam bit THRESH_EN  = 1'b0;
`endif

    // ---------------- write side ----------------
    logic              in_ready_r;
    logic              frame_done_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              wr_en_s;
    logic              wr_last_s;
    logic [ADDR_W-1:0] wr_base_s;
    logic [ADDR_W-1:0] wr_next_s;

    // Write address selection: start-of-frame forces address 0 even at the wrap point.
    always_comb begin
        wr_en_s = in_if.in_valid && in_ready_r;
        if (in_if.in_sof) begin
            wr_base_s = '0;
        end else begin
            wr_base_s = wr_addr_r;
        end
        wr_last_s = (wr_base_s == ADDR_W'(DEPTH - 1));
        if (wr_last_s) begin
            wr_next_s = '0;
        end else begin
            wr_next_s = wr_base_s + 14'(1);
        end
    end

    // Write pointer, ready flag and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r   <= 1'b0;
            frame_done_r <= 1'b0;
            wr_addr_r    <= '0;
        end else begin
            in_ready_r   <= 1'b1;
            frame_done_r <= wr_en_s && wr_last_s;
            if (wr_en_s) begin
                wr_addr_r <= wr_next_s;
            end else begin
                wr_addr_r <= wr_addr_r;
            end
        end
    end

    assign in_if.in_ready = in_ready_r;
    assign frame_done     = frame_done_r;

    // ---------------- scan timing ----------------
    logic             ce_s;
    logic [CNT_W-1:0] hcntr_s;
    logic [CNT_W-1:0] vcntr_s;
    logic             visible_s;
    logic             hs_s;
    logic             vs_s;

    img_out_vga_timing u_timing (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce_s),
        .hcntr   (hcntr_s),
        .vcntr   (vcntr_s),
        .visible (visible_s),
        .hs      (hs_s),
        .vs      (vs_s)
    );

    // ---------------- frame buffer ----------------
    // Read port clocks every clk: the non-ce edge between two ce ticks fetches
    // the address registered by stage 1, so stage 2 sees it on the next tick.
    logic [7:0]        mem_r [DEPTH];
    logic [7:0]        rd_data_r;
    logic [ADDR_W-1:0] rd_addr_r;

    // Block RAM: one write port, registered read-first read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_base_s] <= in_if.in_pix;
        end
        rd_data_r <= mem_r[rd_addr_r];
    end

    // ---------------- stage 1 ----------------
    logic              in_img_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              in_img_r;
    logic              vis_r;
    logic              hs_r;
    logic              vs_r;

    // Image-region test and upscaled buffer address from the raster counters.
    always_comb begin
        in_img_s  = (hcntr_s < CNT_W'(IMG_W)) && (vcntr_s < CNT_W'(IMG_H));
        rd_addr_s = ADDR_W'(vcntr_s >> SCALE_LOG2) * ADDR_W'(WIDTH)
                  + ADDR_W'(hcntr_s >> SCALE_LOG2);
    end

    // Stage 1 register: address and flags captured on ce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_r <= '0;
            in_img_r  <= 1'b0;
            vis_r     <= 1'b0;
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
        end else if (ce_s) begin
            rd_addr_r <= rd_addr_s;
            in_img_r  <= in_img_s;
            vis_r     <= visible_s;
            hs_r      <= hs_s;
            vs_r      <= vs_s;
        end else begin
            rd_addr_r <= rd_addr_r;
            in_img_r  <= in_img_r;
            vis_r     <= vis_r;
            hs_r      <= hs_r;
            vs_r      <= vs_r;
        end
    end

    // ---------------- stage 2 ----------------
    logic [7:0] pix_disp_s;
    logic [7:0] rgb_s;

    // Optional binarisation, then region gating and RGB332 mapping.
    always_comb begin
        if (THRESH_EN) begin
            pix_disp_s = (rd_data_r >= THRESH) ? 8'hFF : 8'h00;
        end else begin
            pix_disp_s = rd_data_r;
        end
        if (in_img_r && vis_r) begin
            rgb_s = grey_to_rgb332(pix_disp_s);
        end else begin
            rgb_s = 8'h00;
        end
    end

    // Stage 2 register: colour and delayed syncs, mutually aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r  <= 3'd0;
            vga_g  <= 3'd0;
            vga_b  <= 2'd0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (ce_s) begin
            vga_r  <= rgb_s[7:5];
            vga_g  <= rgb_s[4:2];
            vga_b  <= rgb_s[1:0];
            vga_hs <= hs_r;
            vga_vs <= vs_r;
        end else begin
            vga_r  <= vga_r;
            vga_g  <= vga_g;
            vga_b  <= vga_b;
            vga_hs <= vga_hs;
            vga_vs <= vga_vs;
        end
    end

endmodule

// File: doc/img_out.md
# img_out

Output stage of the Sobel datapath: accepts processed 8-bit edge pixels in raster order, stores them in a block-RAM frame buffer and scans the buffer out as a 640×480 VGA image with integer upscaling. It is the writer/display counterpart of the input windowing stage, sitting between the Sobel operator and the board VGA pins.

## Interface
- WIDTH, 128: image width in pixels
- HEIGHT, 96: image height in lines
- SCALE, 4: power-of-two replication factor, both axes (WIDTH·SCALE ≤ 640, HEIGHT·SCALE ≤ 480)
- THRESH, 8'd64: binarisation threshold (used only with IMG_OUT_THRESH_EN)

- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-low reset
- in_pix  in  8  processed grey pixel
- in_valid  in  1  in_pix valid this cycle
- in_sof  in  1  qualifies in_valid: pixel is first of frame
- in_ready  out  1  write side accepts data
- frame_done  out  1  one-cycle pulse, last pixel of a frame written
- vga_r  out  3  red
- vga_g  out  3  green
- vga_b  out  2  blue
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low

## Operation
- Frame buffer: WIDTH·HEIGHT × 8 bit, inferred block RAM, one write port, one registered read port, read-first on same-address collision. Contents not cleared by reset.
- Write side (every clk): transfer when in_valid & in_ready. Address = 0 if in_sof, else wr_addr. wr_addr ← address+1, wrapping WIDTH·HEIGHT−1 → 0. frame_done = 1 the cycle after writing address WIDTH·HEIGHT−1. in_ready = 0 in reset, 1 from first clk after release.
- Pixel enable ce toggles every clk (25 MHz); reset value 0.
- hcntr 0..799, vcntr 0..520, advance on ce: hcntr wraps at 799 and increments vcntr; vcntr wraps 520 → 0.
- Horizontal: visible 0–639, sync low 656–751. Vertical: visible 0–479, sync low 490–491.
- Image region: hcntr < WIDTH·SCALE and vcntr < HEIGHT·SCALE; rd_addr = (vcntr>>log2 SCALE)·WIDTH + (hcntr>>log2 SCALE), 14 bits at defaults. Outside image region or blanking: colour 0.
- Colour mapping of pixel p: r = p[7:5], g = p[7:5], b = p[7:6].

## Timing
- Two-stage pipeline, advancing only on ce. Stage 1: register rd_addr, in-image flag, visible flag, hs, vs from counters. Stage 2: register colour from RAM data (gated by flags) and delayed hs/vs.
- All VGA outputs lag counters by exactly 2 ce ticks (4 clk); sync and colour stay mutually aligned.
- Write latency 1 clk; a pixel written ≥ 2 clk before its read address is issued is displayed.
- Reset values: vga_r/g/b = 0, vga_hs = vga_vs = 1, frame_done = 0, in_ready = 0, wr_addr = hcntr = vcntr = 0, pipeline flags 0.
- Reset mid-frame: all above return immediately (async); scan restarts at (0,0); next write goes to address 0.
- in_sof on wr_addr ≠ 0: frame restarts, no frame_done for the truncated frame.
- in_sof at wr_addr = WIDTH·HEIGHT−1 boundary: in_sof wins; address 0 written.

## Configuration
- IMG_OUT_THRESH_EN defined: stored pixel p displayed as 8'hFF if p ≥ THRESH, else 8'h00, applied in stage 2 before colour mapping.
- Undefined: p displayed as-is; THRESH unused.

## Structure
- Shared package: VGA timing constants (H_VIS 640, H_SYNC_S 656, H_SYNC_E 751, H_TOT 800, V_VIS 480, V_SYNC_S 490, V_SYNC_E 491, V_TOT 521), grey-to-RGB332 mapping function.
- One sub-module: vga_timing (ce, hcntr, vcntr, visible, hs, vs); frame buffer and write logic stay in img_out.

## Test plan
- Reset held, release → in_ready 1 next clk, vga_hs/vs 1, colours 0 until first visible pixel.
- Write ramp (pixel n = n mod 256) for full frame → frame_done single pulse after 12288th write; line 0 shows pixels 0..127 each 4 ce ticks wide, repeated on lines 0–3.
- Free-run counters → vga_hs low 96 ce ticks per 800, vga_vs low 2 lines per 521, colour 0 at hcntr ≥ 512 or vcntr ≥ 384.
- in_sof asserted after 500 writes → next pixel lands at address 0, no frame_done for first 500.
- Pixel 8'hE4 at address 0 → vga_r 3'b111, vga_g 3'b111, vga_b 2'b11; with IMG_OUT_THRESH_EN pixel 8'h3F → all 0, 8'h40 → all 1s.
- Assert rst mid-line at hcntr 300 → outputs at reset values same cycle, scan restarts at (0,0) after release.
